// File: rtl/riscv_pkg.sv
// Shared register-file types for the writeback path.
package riscv_pkg;

    localparam int RF_IDX_W    = 6;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 1 << RF_IDX_W;

    typedef struct packed {
        logic [RF_IDX_W-1:0]  rd;
        logic [RF_DATA_W-1:0] data;
    } wb_t;

endpackage

// File: rtl/riscv_wbu_fifo.sv
// Circular FIFO of pending register writes for one execute-unit source.
// Per-entry valid bits let the parent build its pending-write mask.
module riscv_wbu_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  wb_t                    push_entry,
    output wb_t                    head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [DEPTH-1:0]       entry_valid,
    output wb_t [DEPTH-1:0]        entries
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_t [DEPTH-1:0]  mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push in the cycle its head leaves.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_pop) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head    = mem[rd_ptr];
    assign entries = mem;

endmodule

// File: rtl/riscv_wbu.sv
// Writeback unit: per-source write FIFOs, round-robin onto the single
// register-file write port, plus the pending-write hazard mask.
module riscv_wbu
    import riscv_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_SRC-1:0]             src_write_en,
    input  logic [NUM_SRC*RF_IDX_W-1:0]    src_write,
    input  logic [NUM_SRC*RF_DATA_W-1:0]   src_write_data,
    output logic [NUM_SRC-1:0]             src_full,
    output logic                           register_write_en,
    output logic [RF_IDX_W-1:0]            register_write,
    output logic [RF_DATA_W-1:0]           register_write_data,
    output logic [RF_NUM_REGS-1:0]         pending,
    output logic                           idle,
    output logic                           overflow_err
);

    localparam int RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]    push;
    logic [NUM_SRC-1:0]    pop;
    logic [NUM_SRC-1:0]    empty;
    wb_t                   push_entry  [NUM_SRC];
    wb_t                   head        [NUM_SRC];
    wb_t [DEPTH-1:0]       entries     [NUM_SRC];
    logic [DEPTH-1:0]      entry_valid [NUM_SRC];
    logic [$clog2(DEPTH):0] fifo_count [NUM_SRC];

    logic [RR_W-1:0] rr_ptr;
    logic [RR_W-1:0] rr_next;
    logic [RR_W-1:0] grant_idx;
    logic            grant_vld;
    logic            fifo_busy;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        // Writes to x0 have no architectural effect and are dropped here.
        assign push[i] = src_write_en[i] &&
                         (src_write[i*RF_IDX_W +: RF_IDX_W] != '0);
        assign push_entry[i] = {src_write[i*RF_IDX_W +: RF_IDX_W],
                                src_write_data[i*RF_DATA_W +: RF_DATA_W]};

        riscv_wbu_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clock       (clock),
            .reset       (reset),
            .push        (push[i]),
            .pop         (pop[i]),
            .push_entry  (push_entry[i]),
            .head        (head[i]),
            .full        (src_full[i]),
            .empty       (empty[i]),
            .count       (fifo_count[i]),
            .entry_valid (entry_valid[i]),
            .entries     (entries[i])
        );
    end

    always_comb begin
        logic [RR_W-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        pop       = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = RR_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (!grant_vld && !empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant_vld) begin
            pop[grant_idx] = 1'b1;
        end
        rr_next = (grant_idx == RR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr              <= '0;
            register_write_en   <= 1'b0;
            register_write      <= '0;
            register_write_data <= '0;
            overflow_err        <= 1'b0;
        end else begin
            register_write_en <= grant_vld;
            if (grant_vld) begin
                rr_ptr              <= rr_next;
                register_write      <= head[grant_idx].rd;
                register_write_data <= head[grant_idx].data;
            end
            if (|(push & src_full & ~pop)) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Hazard mask covers queued entries and the write currently on the port.
    always_comb begin
        pending   = '0;
        fifo_busy = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (fifo_count[i] != '0) begin
                fifo_busy = 1'b1;
            end
            for (int j = 0; j < DEPTH; j++) begin
                if (entry_valid[i][j]) begin
                    pending[entries[i][j].rd] = 1'b1;
                end
            end
        end
        if (register_write_en) begin
            pending[register_write] = 1'b1;
        end
    end

    assign idle = !fifo_busy && !register_write_en;

endmodule

// File: tb/tb_riscv_wbu.sv
// Directed bench for riscv_wbu with a per-source write scoreboard.
module tb_riscv_wbu;
    import riscv_pkg::*;

    localparam int NUM_SRC = 3;
    localparam int DEPTH   = 2;

    logic                         clock = 1'b0;
    logic                         reset;
    logic [NUM_SRC-1:0]           src_write_en;
    logic [NUM_SRC*RF_IDX_W-1:0]  src_write;
    logic [NUM_SRC*RF_DATA_W-1:0] src_write_data;
    logic [NUM_SRC-1:0]           src_full;
    logic                         register_write_en;
    logic [RF_IDX_W-1:0]          register_write;
    logic [RF_DATA_W-1:0]         register_write_data;
    logic [RF_NUM_REGS-1:0]       pending;
    logic                         idle;
    logic                         overflow_err;

    int  checks   = 0;
    int  failures = 0;
    wb_t exp_q [NUM_SRC][$];

    riscv_wbu #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) dut (
        .clock               (clock),
        .reset               (reset),
        .src_write_en        (src_write_en),
        .src_write           (src_write),
        .src_write_data      (src_write_data),
        .src_full            (src_full),
        .register_write_en   (register_write_en),
        .register_write      (register_write),
        .register_write_data (register_write_data),
        .pending             (pending),
        .idle                (idle),
        .overflow_err        (overflow_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input int s, input logic [5:0] idx, input logic [31:0] d);
        wb_t e;
        src_write_en[s]           = 1'b1;
        src_write[s*6 +: 6]       = idx;
        src_write_data[s*32 +: 32] = d;
        e.rd   = idx;
        e.data = d;
        if (idx != 6'd0) exp_q[s].push_back(e);
    endtask

    task automatic quiet();
        src_write_en = '0;
    endtask

    task automatic clear_sb();
        for (int s = 0; s < NUM_SRC; s++) exp_q[s].delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_sb();
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic int sb_left();
        int n = 0;
        for (int s = 0; s < NUM_SRC; s++) n += exp_q[s].size();
        return n;
    endfunction

    // Every register-file write must match the oldest outstanding write of some source.
    always @(negedge clock) begin
        bit found;
        if (!reset && register_write_en) begin
            found = 1'b0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (!found && exp_q[s].size() > 0 &&
                    exp_q[s][0].rd === register_write &&
                    exp_q[s][0].data === register_write_data) begin
                    found = 1'b1;
                    void'(exp_q[s].pop_front());
                end
            end
            checks++;
            assert (found) else begin
                failures++;
                $error("FAIL sb_write: observed x%0d=%h, expected head of a source queue",
                       register_write, register_write_data);
            end
        end
    end

    initial begin
        reset          = 1'b1;
        src_write_en   = '0;
        src_write      = '0;
        src_write_data = '0;
        tick();
        chk("rst_en",       register_write_en,   0);
        chk("rst_reg",      register_write,      0);
        chk("rst_data",     register_write_data, 0);
        chk("rst_ovf",      overflow_err,        0);
        chk("rst_pending",  pending,             0);
        chk("rst_idle",     idle,                1);
        chk("rst_full",     src_full,            0);
        tick();
        reset = 1'b0;

        // single ALU write
        put(0, 6'd5, 32'h1234);
        tick(); quiet();
        chk("t1_pend_t1",  pending[5],          1);
        chk("t1_en_t1",    register_write_en,   0);
        chk("t1_idle_t1",  idle,                0);
        tick();
        chk("t1_en_t2",    register_write_en,   1);
        chk("t1_reg_t2",   register_write,      5);
        chk("t1_data_t2",  register_write_data, 32'h1234);
        chk("t1_pend_t2",  pending[5],          1);
        tick();
        chk("t1_pend_t3",  pending[5],          0);
        chk("t1_idle_t3",  idle,                1);
        chk("t1_en_t3",    register_write_en,   0);
        chk("t1_hold_reg", register_write,      5);

        // x0 write discarded
        put(1, 6'd0, 32'hFFFF);
        tick(); quiet();
        chk("t2_pending",  pending,             0);
        chk("t2_ovf",      overflow_err,        0);
        chk("t2_idle",     idle,                1);
        tick();
        chk("t2_en",       register_write_en,   0);

        // simultaneous pushes from all sources
        do_reset();
        put(0, 6'd1, 32'hA);
        put(1, 6'd2, 32'hB);
        put(2, 6'd3, 32'hC);
        tick(); quiet();
        chk("t3_pending",  pending,             64'hE);
        tick();
        chk("t3_w0",       register_write,      1);
        tick();
        chk("t3_w1",       register_write,      2);
        tick();
        chk("t3_w2",       register_write,      3);
        chk("t3_w2_data",  register_write_data, 32'hC);
        tick();
        chk("t3_idle",     idle,                1);
        put(1, 6'd4, 32'hD);
        put(0, 6'd6, 32'hE);
        tick(); quiet();
        tick();
        chk("t3_rr_first", register_write,      6);
        tick();
        chk("t3_rr_second", register_write,     4);
        tick();
        chk("t3_drained",  sb_left(),           0);

        // in-order drain of src0 under contention
        do_reset();
        put(1, 6'd10, 32'h11); put(2, 6'd20, 32'h21);
        tick(); quiet();
        put(0, 6'd7, 32'h1); put(1, 6'd11, 32'h12); put(2, 6'd21, 32'h22);
        tick(); quiet();
        chk("t4_e2_reg",   register_write,      10);
        chk("t4_e2_full",  src_full,            3'b100);
        put(0, 6'd7, 32'h2); put(1, 6'd12, 32'h13);
        tick(); quiet();
        chk("t4_e3_reg",   register_write,      20);
        chk("t4_e3_full",  src_full,            3'b011);
        put(0, 6'd7, 32'h3); put(2, 6'd22, 32'h23);
        tick(); quiet();
        chk("t4_e4_reg",   register_write,      7);
        chk("t4_e4_data",  register_write_data, 32'h1);
        chk("t4_e4_full",  src_full,            3'b111);
        chk("t4_e4_ovf",   overflow_err,        0);
        tick();
        chk("t4_e5_reg",   register_write,      11);
        for (int i = 0; i < 6; i++) tick();
        chk("t4_idle",     idle,                1);
        chk("t4_drained",  sb_left(),           0);

        // overflow on src2
        do_reset();
        put(0, 6'd1, 32'h51); put(1, 6'd2, 32'h52); put(2, 6'd20, 32'h31);
        tick(); quiet();
        put(2, 6'd21, 32'h32);
        tick(); quiet();
        chk("t5_full2",    src_full[2],         1);
        chk("t5_ovf_pre",  overflow_err,        0);
        src_write_en[2]     = 1'b1;
        src_write[12 +: 6]  = 6'd22;
        src_write_data[64 +: 32] = 32'h33;
        tick(); quiet();
        chk("t5_ovf_set",  overflow_err,        1);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_ovf_sticky", overflow_err,      1);
        chk("t5_idle",     idle,                1);
        chk("t5_drained",  sb_left(),           0);

        // reset with writes queued
        put(0, 6'd1, 32'h61); put(1, 6'd2, 32'h62); put(2, 6'd3, 32'h63);
        tick(); quiet();
        tick();
        chk("t6_en_live",  register_write_en,   1);
        reset = 1'b1;
        clear_sb();
        #1;
        chk("t6_en",       register_write_en,   0);
        chk("t6_reg",      register_write,      0);
        chk("t6_data",     register_write_data, 0);
        chk("t6_pending",  pending,             0);
        chk("t6_ovf",      overflow_err,        0);
        chk("t6_full",     src_full,            0);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_write", register_write_en, 0);
        end
        chk("t6_idle",     idle,                1);
        chk("final_sb",    sb_left(),           0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
